fir_tap_sequencer: RTL and testbench

- Upstream feeder for the FIR `mac` stage.
- Holds the sample history in a circular delay line and a programmable coefficient bank.
- For each accepted input sample, streams TAP_NUM (sample, coefficient) pairs into the MAC. It then issues one zero-operand flush cycle and one `calculated` dump cycle, so the MAC's registered product and accumulator drain cleanly.
- Flags the cycle in which the MAC's `data_out` holds the new filter result.

---
 rtl/fir_pkg.sv | 9 +
 rtl/fir_tap_sequencer_if.sv | 29 ++
 rtl/fir_delay_line.sv | 31 +++
 rtl/fir_tap_sequencer.sv | 117 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, frame length and FSM state encoding for the FIR tap sequencer.
package fir_pkg;
  localparam int DEF_DATA_BIT_NUM  = 16;
  localparam int DEF_COEFF_BIT_NUM = 16;
  localparam int DEF_TAP_NUM       = 8;
  localparam int FRAME_CYCLES      = DEF_TAP_NUM + 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DUMP} state_e;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample stream, coefficient write port and MAC-facing operand bus of the sequencer.
interface fir_tap_sequencer_if #(
  parameter int DATA_BIT_NUM  = 16,
  parameter int COEFF_BIT_NUM = 16,
  parameter int TAP_NUM       = 8,
  parameter int ADDR_BITS     = $clog2(TAP_NUM)
);
  logic                            sample_valid;
  logic signed [DATA_BIT_NUM-1:0]  sample_in;
  logic                            sample_ready;
  logic                            coeff_wr_en;
  logic        [ADDR_BITS-1:0]     coeff_wr_addr;
  logic signed [COEFF_BIT_NUM-1:0] coeff_wr_data;
  logic signed [DATA_BIT_NUM-1:0]  data_delay_out;
  logic signed [COEFF_BIT_NUM-1:0] coeffs_out;
  logic                            calculated;
  logic                            busy;
  logic                            result_strobe;

  modport master (
    output sample_valid, sample_in, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    input  sample_ready, data_delay_out, coeffs_out, calculated, busy, result_strobe
  );

  modport slave (
    input  sample_valid, sample_in, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    output sample_ready, data_delay_out, coeffs_out, calculated, busy, result_strobe
  );
endinterface

// File: rtl/fir_delay_line.sv
// Circular sample history: write advances the pointer, read is combinational at (wr_ptr - offset).
module fir_delay_line #(
  parameter int DATA_BIT_NUM = 16,
  parameter int TAP_NUM      = 8,
  parameter int ADDR_BITS    = $clog2(TAP_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic signed [DATA_BIT_NUM-1:0] wr_data,
  input  logic        [ADDR_BITS-1:0]    rd_offset,
  output logic signed [DATA_BIT_NUM-1:0] rd_data
);
  logic [TAP_NUM-1:0][DATA_BIT_NUM-1:0] mem;
  logic [ADDR_BITS-1:0]                 wr_ptr, wr_ptr_nxt, rd_addr;

  // Pointer arithmetic wraps by ADDR_BITS overflow, TAP_NUM is a power of two.
  assign wr_ptr_nxt = wr_ptr + ADDR_BITS'(1);
  assign rd_addr    = wr_ptr - rd_offset;
  assign rd_data    = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      mem    <= '0;
    end else if (wr_en) begin
      wr_ptr           <= wr_ptr_nxt;
      mem[wr_ptr_nxt]  <= wr_data;
    end
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Streams TAP_NUM (sample, coeff) pairs per accepted sample into the MAC, then flush + dump cycles.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_BIT_NUM  = DEF_DATA_BIT_NUM,
  parameter int COEFF_BIT_NUM = DEF_COEFF_BIT_NUM,
  parameter int TAP_NUM       = DEF_TAP_NUM,
  parameter int ADDR_BITS     = $clog2(TAP_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_tap_sequencer_if.slave bus
);
  state_e                              state, state_nxt;
  logic [ADDR_BITS-1:0]                tap_cnt, tap_nxt, tap_inc;
  logic [TAP_NUM-1:0][COEFF_BIT_NUM-1:0] coeff;
  logic signed [DATA_BIT_NUM-1:0]      hist_rd, data_nxt;
  logic signed [COEFF_BIT_NUM-1:0]     coeff_nxt;
  logic                                accept, calc_nxt, strobe_nxt, ready_nxt, busy_nxt;

  assign tap_inc = tap_cnt + ADDR_BITS'(1);

  fir_delay_line #(
    .DATA_BIT_NUM (DATA_BIT_NUM),
    .TAP_NUM      (TAP_NUM),
    .ADDR_BITS    (ADDR_BITS)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (accept),
    .wr_data   (bus.sample_in),
    .rd_offset (tap_inc),
    .rd_data   (hist_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coeff <= '0;
    else if (bus.coeff_wr_en) coeff[bus.coeff_wr_addr] <= bus.coeff_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tap_cnt <= tap_nxt;
    end
  end

  // Outputs are registered, so each edge loads the operands for the following cycle.
  // Tap 0 bypasses the history since the sample lands in the delay line on the same edge.
  always_comb begin
    state_nxt  = state;
    tap_nxt    = tap_cnt;
    accept     = 1'b0;
    data_nxt   = '0;
    coeff_nxt  = '0;
    calc_nxt   = 1'b0;
    strobe_nxt = 1'b0;
    ready_nxt  = 1'b0;
    busy_nxt   = 1'b1;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (bus.sample_valid && bus.sample_ready) begin
          accept    = 1'b1;
          state_nxt = RUN;
          tap_nxt   = '0;
          data_nxt  = bus.sample_in;
          coeff_nxt = coeff[0];
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (tap_cnt == ADDR_BITS'(TAP_NUM - 1)) begin
          state_nxt = FLUSH;
        end else begin
          tap_nxt   = tap_inc;
          data_nxt  = hist_rd;
          coeff_nxt = coeff[tap_inc];
        end
      end
      FLUSH: begin
        state_nxt = DUMP;
        calc_nxt  = 1'b1;
      end
      DUMP: begin
        state_nxt  = IDLE;
        strobe_nxt = 1'b1;
        ready_nxt  = 1'b1;
        busy_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_delay_out <= '0;
      bus.coeffs_out     <= '0;
      bus.calculated     <= 1'b0;
      bus.result_strobe  <= 1'b0;
      bus.sample_ready   <= 1'b1;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_delay_out <= data_nxt;
      bus.coeffs_out     <= coeff_nxt;
      bus.calculated     <= calc_nxt;
      bus.result_strobe  <= strobe_nxt;
      bus.sample_ready   <= ready_nxt;
      bus.busy           <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with a behavioural MAC and a result scoreboard.
module tb_fir_tap_sequencer;
  localparam int DW = 16, CW = 16, TN = 8, FC = TN + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.DATA_BIT_NUM(DW), .COEFF_BIT_NUM(CW), .TAP_NUM(TN)) bus ();

  fir_tap_sequencer #(.DATA_BIT_NUM(DW), .COEFF_BIT_NUM(CW), .TAP_NUM(TN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Downstream MAC: registered product, accumulator, dump on calculated.
  logic signed [DW+CW-1:0] prod, acc, mac_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0; acc <= '0; mac_out <= '0;
    end else begin
      prod <= bus.data_delay_out * bus.coeffs_out;
      if (bus.calculated) begin
        mac_out <= acc + prod;
        acc     <= '0;
      end else begin
        acc <= acc + prod;
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int cyc = -1, tcyc = 0, n_acc = 0, e;
  int hist[TN] = '{default: 0};
  int hm[TN]   = '{default: 0};
  int fx[TN]   = '{default: 0};
  int fh[TN]   = '{default: 0};
  int sb[$], res_log[$], stamps[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: checks every cycle against frame position, pushes/pops the scoreboard.
  always @(negedge clk) begin
    tcyc++;
    if (!rst_n) begin
      chk("rst_data", bus.data_delay_out, 0);
      chk("rst_coeff", bus.coeffs_out, 0);
      chk("rst_calc", bus.calculated, 0);
      chk("rst_strobe", bus.result_strobe, 0);
      chk("rst_busy", bus.busy, 0);
      cyc = -1;
      sb.delete();
      for (int k = 0; k < TN; k++) begin hist[k] = 0; hm[k] = 0; end
    end else begin
      if (cyc >= 0) cyc++;
      if (cyc > FC) cyc = -1;
      if (cyc >= 1 && cyc <= TN) begin
        chk("tap_data", bus.data_delay_out, 16'(fx[cyc-1]));
        chk("tap_coeff", bus.coeffs_out, 16'(fh[cyc-1]));
        chk("run_calc", bus.calculated, 0);
        chk("run_ready", bus.sample_ready, 0);
        chk("run_busy", bus.busy, 1);
        chk("run_strobe", bus.result_strobe, 0);
      end else if (cyc == TN + 1 || cyc == TN + 2) begin
        chk("tail_data", bus.data_delay_out, 0);
        chk("tail_coeff", bus.coeffs_out, 0);
        chk("tail_calc", bus.calculated, cyc == TN + 2);
        chk("tail_ready", bus.sample_ready, 0);
        chk("tail_busy", bus.busy, 1);
        chk("tail_strobe", bus.result_strobe, 0);
      end else begin
        chk("idle_data", bus.data_delay_out, 0);
        chk("idle_coeff", bus.coeffs_out, 0);
        chk("idle_calc", bus.calculated, 0);
        chk("idle_ready", bus.sample_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("strobe", bus.result_strobe, cyc == FC);
        if (cyc == FC) begin
          stamps.push_back(tcyc);
          if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
          else begin
            e = sb.pop_front();
            res_log.push_back(mac_out);
            chk("result", mac_out, e);
          end
        end
      end
      if (bus.sample_valid && bus.sample_ready) begin
        for (int k = TN - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = bus.sample_in;
        e = 0;
        for (int k = 0; k < TN; k++) begin
          fx[k] = hist[k]; fh[k] = hm[k]; e += hist[k] * hm[k];
        end
        sb.push_back(e);
        cyc = 0;
        n_acc++;
      end
      if (bus.coeff_wr_en) hm[bus.coeff_wr_addr] = bus.coeff_wr_data;
    end
  end

  // All driver tasks start and end #1 after a rising edge.
  task automatic wr_coeff(input int a, input int d);
    bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 3'(a); bus.coeff_wr_data = 16'(d);
    @(posedge clk); #1;
    bus.coeff_wr_en = 1'b0;
  endtask

  task automatic send(input logic signed [DW-1:0] x, input bit hold);
    bit ok = 1'b0;
    bus.sample_valid = 1'b1; bus.sample_in = x;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.sample_ready;
    end
    chk("send_timeout", ok, 1);
    @(posedge clk); #1;
    if (!hold) bus.sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      done = (cyc == -1) && (sb.size() == 0);
    end
    #1;
    chk("idle_timeout", done, 1);
  endtask

  int na;

  initial begin
    bus.sample_valid = 1'b0; bus.sample_in = '0;
    bus.coeff_wr_en = 1'b0; bus.coeff_wr_addr = '0; bus.coeff_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.sample_ready, 1);
    @(posedge clk); #1;

    // Impulse response, h = 1..8
    for (int k = 0; k < TN; k++) wr_coeff(k, k + 1);
    res_log.delete();
    send(1, 0);
    for (int i = 0; i < TN - 1; i++) send(0, 0);
    wait_idle();
    chk("imp_count", res_log.size(), TN);
    for (int m = 0; m < res_log.size(); m++) chk("imp_result", res_log[m], m + 1);

    // Coefficient update while idle, impulse reaches tap 3 on the fourth frame
    wr_coeff(3, -2);
    res_log.delete();
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    wait_idle();
    chk("coef_count", res_log.size(), 4);
    if (res_log.size() == 4) chk("coef_result", res_log[3], -2);

    // Reset mid-frame, then a fresh sample sees zero history and cleared coefficients
    send(16'sd9, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wr_coeff(0, 3);
    res_log.delete();
    send(16'sd5, 0);
    wait_idle();
    chk("rst_count", res_log.size(), 1);
    if (res_log.size() == 1) chk("rst_result", res_log[0], 15);

    // Back-to-back with wrap, all h = 1, clean history
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < TN; k++) wr_coeff(k, 1);
    res_log.delete(); stamps.delete();
    for (int i = 1; i <= 20; i++) send(16'(i), i < 20);
    wait_idle();
    chk("b2b_count", res_log.size(), 20);
    if (res_log.size() == 20) begin
      chk("b2b_first", res_log[0], 1);
      chk("b2b_eighth", res_log[7], 36);
      chk("b2b_last", res_log[19], 132);
      for (int i = 1; i < 20; i++) chk("b2b_gap", stamps[i] - stamps[i-1], FC);
    end

    // Backpressure: valid raised mid-frame is taken only in the IDLE cycle, once
    na = n_acc;
    stamps.delete(); res_log.delete();
    send(16'sd1, 0);
    repeat (3) @(posedge clk);
    #1;
    send(16'sh7FFF, 0);
    wait_idle();
    chk("bp_accepts", n_acc - na, 2);
    chk("bp_count", stamps.size(), 2);
    if (stamps.size() == 2) chk("bp_gap", stamps[1] - stamps[0], FC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
